// File: rtl/split_gen_pkg.sv
// Shared types and helpers for the split-checker stimulus generator:
// FSM state encoding, the xorshift32 step and the zero-seed substitute.
package split_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_EVAL,
    ST_EMIT,
    ST_FIN
  } state_t;

  localparam logic [31:0] ZERO_SEED_SUB = 32'h1;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // xorshift32 is stuck at zero forever, so a zero seed is never loaded.
  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? ZERO_SEED_SUB : s;
  endfunction

endpackage

// File: rtl/split_prng32.sv
// xorshift32 state register. `word` is the value the next step will produce,
// so the consumer can capture it in the same cycle it asserts `step`.
module split_prng32
  import split_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] word
);

  logic [31:0] r_state;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= fix_seed(SEED);
    end else if (load) begin
      r_state <= fix_seed(seed);
    end else if (step) begin
      r_state <= xorshift32(r_state);
    end
  end

  assign word = xorshift32(r_state);

endmodule

// File: rtl/split_stim_gen.sv
// Pseudo-random candidate generator for a combinational split checker.
// Optional macro SPLIT_GEN_SEED_LOAD_EN adds a seed_in port loaded on start.
module split_stim_gen
  import split_gen_pkg::*;
#(
  parameter int          ASSIGN_W  = 64,
  parameter logic [31:0] SEED      = 32'hACE1_2468,
  parameter int          MAX_TRIES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         target_count,
`ifdef SPLIT_GEN_SEED_LOAD_EN
  input  logic [31:0]         seed_in,
`endif
  output logic [ASSIGN_W-1:0] cand_data,
  input  logic                chk_x,
  output logic                sol_valid,
  output logic [ASSIGN_W-1:0] sol_data,
  input  logic                sol_ready,
  output logic                busy,
  output logic                done,
  output logic                exhausted,
  output logic [15:0]         sol_cnt,
  output logic [15:0]         try_cnt
);

  localparam int             NW     = ASSIGN_W / 32;
  localparam int             IW     = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0]  LAST_W = IW'(NW - 1);
  localparam logic [15:0]    MAX_T  = 16'(MAX_TRIES);

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [15:0]         r_target;
  logic [ASSIGN_W-1:0] r_cand;
  logic [ASSIGN_W-1:0] r_sol;
  logic                r_sol_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_exh;
  logic [15:0]         r_sol_cnt;
  logic [15:0]         r_try_cnt;

  logic                w_load;
  logic                w_step;
  logic [31:0]         w_seed;
  logic [31:0]         w_word;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_step = (r_state == ST_GEN);

`ifdef SPLIT_GEN_SEED_LOAD_EN
  assign w_seed = seed_in;
`else
  assign w_seed = SEED;
`endif

  split_prng32 #(.SEED(SEED)) u_prng (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .seed (w_seed),
    .step (w_step),
    .word (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_target    <= '0;
      r_cand      <= '0;
      r_sol       <= '0;
      r_sol_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_exh       <= 1'b0;
      r_sol_cnt   <= '0;
      r_try_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sol_cnt <= '0;
            r_try_cnt <= '0;
            r_exh     <= 1'b0;
            r_target  <= target_count;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            if (target_count == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_GEN;
            end
          end
        end
        ST_GEN: begin
          for (int k = 0; k < NW; k++) begin
            if (r_idx == IW'(k)) r_cand[32*k +: 32] <= w_word;
          end
          if (r_idx == LAST_W) begin
            r_idx   <= '0;
            r_state <= ST_EVAL;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_EVAL: begin
          r_try_cnt <= r_try_cnt + 16'd1;
          if (chk_x) begin
            r_sol       <= r_cand;
            r_sol_cnt   <= r_sol_cnt + 16'd1;
            r_sol_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (r_try_cnt + 16'd1 == MAX_T) begin
            r_exh   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_GEN;
          end
        end
        ST_EMIT: begin
          // The budget test here sees the count already bumped in EVAL.
          if (sol_ready) begin
            r_sol_valid <= 1'b0;
            if (r_sol_cnt == r_target) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else if (r_try_cnt == MAX_T) begin
              r_exh   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_GEN;
            end
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cand_data = r_cand;
  assign sol_valid = r_sol_valid;
  assign sol_data  = r_sol;
  assign busy      = r_busy;
  assign done      = r_done;
  assign exhausted = r_exh;
  assign sol_cnt   = r_sol_cnt;
  assign try_cnt   = r_try_cnt;

endmodule

// File: doc/split_stim_gen.md
# split_stim_gen

Sequential stimulus source for the split constraint checkers of the BDD solver flow. It generates pseudo-random candidate assignments one 32-bit word per cycle and presents each full assignment to a combinational split checker. It samples the checker's single-bit verdict and forwards satisfying assignments downstream over a valid/ready handshake. It stops after a programmed number of solutions or after a try budget is exhausted.

## Interface
- `ASSIGN_W`, default 64: candidate assignment width in bits; must be a multiple of 32 and ≥ 32.
- `SEED`, default 32'hACE1_2468: xorshift32 reset/start seed. The value 0 is replaced by 32'h1.
- `MAX_TRIES`, default 1024: maximum number of candidates evaluated per run, range 1..65535.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a run; only accepted in IDLE.
- `target_count` in 16: number of solutions requested; sampled on an accepted `start`.
- `cand_data` out ASSIGN_W: candidate assignment, wired to the checker's concatenated variable inputs.
- `chk_x` in 1: checker verdict for `cand_data`, returned combinationally.
- `sol_valid` out 1: a satisfying assignment is available.
- `sol_data` out ASSIGN_W: the satisfying assignment.
- `sol_ready` in 1: downstream accepts the solution.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: single-cycle pulse at the end of a run.
- `exhausted` out 1: level signal; the last run ended because the try budget ran out.
- `sol_cnt` out 16: number of solutions emitted in the current or last run.
- `try_cnt` out 16: number of candidates evaluated in the current or last run.

## Operation
- **Reset:**
  - FSM goes to IDLE.
  - All outputs are 0.
  - PRNG state is loaded with `SEED`.
  - Reset has priority in every state, including mid-run; any partial assignment is discarded.
- **FSM states:** IDLE, GEN, EVAL, EMIT, FIN.
- **IDLE:**
  - On `start`: clear `sol_cnt`, `try_cnt` and `exhausted`; latch `target_count`; reload the PRNG seed.
  - If the latched target is 0, go to FIN; otherwise go to GEN with word index 0.
- **GEN:**
  - Each cycle: `s ^= s<<13; s ^= s>>17; s ^= s<<5`.
  - The new `s` is written into `cand_data[32*i +: 32]`, and `i` increments.
  - After word `ASSIGN_W/32-1` is written, go to EVAL.
- **EVAL:** `cand_data` is stable and `chk_x` is sampled. `try_cnt` increments in this cycle.
  - If `chk_x`=1: copy `cand_data` to `sol_data`, increment `sol_cnt`, go to EMIT.
  - Else if `try_cnt+1 == MAX_TRIES`: set `exhausted`, go to FIN.
  - Else: go to GEN.
- **EMIT:**
  - `sol_valid`=1 and `sol_data` are held stable until `sol_valid && sol_ready`.
  - After the handshake:
    - If `sol_cnt == target`, go to FIN.
    - Else if `try_cnt == MAX_TRIES`, set `exhausted` and go to FIN.
    - Else go to GEN.
- **FIN:** pulse `done` for one cycle, then go to IDLE.
- **Boundary rules:**
  - `start` while busy is ignored.
  - Counters never wrap, because `MAX_TRIES` ≤ 65535.
  - `sol_ready` held high before `sol_valid` has no effect.
  - The PRNG continues from its current state across GEN passes within a run.

## Timing
- One GEN pass takes W = `ASSIGN_W/32` cycles; EVAL takes 1 cycle. A rejected try therefore costs W+1 cycles.
- With `start` high at cycle 0: GEN occupies cycles 1..W and EVAL is cycle W+1. `sol_valid` rises at cycle W+2 at the earliest.
- EMIT with `sol_ready` tied high lasts 1 cycle, so an accepted try costs W+2 cycles.
- `done` asserts in the cycle after the terminating EVAL/EMIT transition. `busy` falls in the cycle after `done`.
- `target_count`=0: `done` at cycle 1, `busy` low at cycle 2.

## Configuration
- `SPLIT_GEN_SEED_LOAD_EN` defined:
  - Adds input `seed_in` [31:0].
  - An accepted `start` loads the PRNG from `seed_in`, with 0 mapped to 32'h1.
  - Reset still loads `SEED`.
- Not defined: no `seed_in` port; every accepted `start` reloads `SEED`, so runs are repeatable.

## Structure
- Shared package `split_gen_pkg` holds:
  - the FSM state enum;
  - the `xorshift32` function;
  - the zero-seed replacement constant 32'h1.
- One sub-module, `split_prng32`: holds the xorshift32 state register, with `load`, `seed`, `step` inputs and `word` output. The top level owns the FSM, the assignment register and the counters.

## Test plan
- `ASSIGN_W`=64, `chk_x` tied 1, `target_count`=3, `sol_ready`=1.
  - Expect 3 `sol_valid` pulses at cycles 4, 8, 12.
  - `sol_data` matches the xorshift model from `SEED`.
  - `done` at 13; `sol_cnt`=3, `try_cnt`=3, `exhausted`=0.
- `chk_x` tied 0, `MAX_TRIES`=4: no `sol_valid`; `done` at cycle 13; `try_cnt`=4, `exhausted`=1.
- Backpressure: hold `sol_ready`=0 for 5 cycles in EMIT.
  - `sol_valid` and `sol_data` stay stable; the PRNG does not advance.
  - The handshake completes on the cycle `sol_ready` rises.
- `target_count`=0: `done` at cycle 1, no GEN cycles, `try_cnt`=0.
- Assert `rst` mid-GEN, then `start`: the first word equals `xorshift(SEED)`; `sol_cnt`/`try_cnt` are 0 right after reset.
- `start` pulsed while busy is ignored and the counters continue. Under `SPLIT_GEN_SEED_LOAD_EN`, `seed_in`=0 yields a first word of `xorshift(32'h1)` = 32'h0004_2021.
